decim_clk_gen: RTL and testbench



---
 rtl/decim_clk_if.sv | 61 ++++++
 rtl/decim_clk_gen.sv | 133 +++++++++++++
 tb/tb_decim_clk_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decim_clk_if.sv
// -----------------------------------------------------------------------------
// decim_clk_if
//
// Bundles the control and status signals of the decimation clock generator.
//
//   master : the consumer side. Drives enable / log2Ratio (and syncIn when
//            built with DECIM_CLK_SYNC_EN). Observes strobe, clkOut, phase,
//            activeLog2 and ratioAck.
//   slave  : the generator side (decim_clk_gen).
//
// Signals
//   enable      count enable; low freezes the generator state
//   log2Ratio   requested log2 divide ratio (clamped inside the generator)
//   syncIn      phase-alignment pulse (only with DECIM_CLK_SYNC_EN)
//   strobe      one-cycle pulse per completed period
//   clkOut      registered 50%-duty divided clock
//   phase       current count value
//   activeLog2  ratio currently in effect
//   ratioAck    one-cycle pulse when a new ratio has been applied
//
// Optional feature macro: DECIM_CLK_SYNC_EN (adds syncIn).
// -----------------------------------------------------------------------------
interface decim_clk_if #(
  parameter int MAX_LOG2 = 8
);
  localparam int LW = $clog2(MAX_LOG2 + 1);

  logic                enable;
  logic [LW-1:0]       log2Ratio;
`ifdef DECIM_CLK_SYNC_EN
  logic                syncIn;
`endif
  logic                strobe;
  logic                clkOut;
  logic [MAX_LOG2-1:0] phase;
  logic [LW-1:0]       activeLog2;
  logic                ratioAck;

`ifdef DECIM_CLK_SYNC_EN
  modport master (
    output enable, log2Ratio, syncIn,
    input  strobe, clkOut, phase, activeLog2, ratioAck
  );

  modport slave (
    input  enable, log2Ratio, syncIn,
    output strobe, clkOut, phase, activeLog2, ratioAck
  );
`else
  modport master (
    output enable, log2Ratio,
    input  strobe, clkOut, phase, activeLog2, ratioAck
  );

  modport slave (
    input  enable, log2Ratio,
    output strobe, clkOut, phase, activeLog2, ratioAck
  );
`endif

endinterface : decim_clk_if

// File: rtl/decim_clk_gen.sv
// -----------------------------------------------------------------------------
// decim_clk_gen
//
// Synchronous, counter-based clock divider for the decimation chain. Produces
// a one-cycle clock-enable strobe every 2^L input cycles, a registered
// 50%-duty divided clock and the running phase count. L is selectable at run
// time; a new ratio is only adopted at a period boundary, so no period is ever
// truncated or stretched.
//
// Parameters
//   MAX_LOG2      largest supported log2 ratio (phase counter width)
//   DEFAULT_LOG2  ratio loaded at reset, 1 <= DEFAULT_LOG2 <= MAX_LOG2
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   decim_clk_if.slave:
//           in : enable, log2Ratio (, syncIn)
//           out: strobe, clkOut, phase, activeLog2, ratioAck
//
// Optional feature macro: DECIM_CLK_SYNC_EN
//   When defined, bus.syncIn restarts the period (phase 0, clkOut 0) and
//   adopts the pending ratio immediately, regardless of enable. rst still
//   takes priority. Used to phase-align several generators.
// -----------------------------------------------------------------------------
module decim_clk_gen #(
  parameter int MAX_LOG2     = 8,
  parameter int DEFAULT_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst,
  decim_clk_if.slave bus
);

  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int PW = MAX_LOG2;

  localparam logic [LW-1:0] DEFAULT_L = LW'(DEFAULT_LOG2);
  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LOG2);
  localparam logic [LW-1:0] MIN_L     = LW'(1);

  // Registered state; every output is a direct register copy.
  logic [PW-1:0] phase;
  logic [LW-1:0] activeLog2;
  logic [LW-1:0] pendingLog2;
  logic          strobe;
  logic          clkOut;
  logic          ratioAck;

  // Next-state helpers.
  logic [LW-1:0] reqClamped;
  logic [PW-1:0] phaseInc;
  logic          atWrap;
  logic          ratioChange;

  // Last phase value of a period of length 2^l. Computed one bit wider so
  // that l == MAX_LOG2 yields all-ones instead of overflowing.
  function automatic logic [PW-1:0] lastPhase(input logic [LW-1:0] l);
    lastPhase = PW'(((PW + 1)'(1) << l) - (PW + 1)'(1));
  endfunction

  // One-hot mask selecting bit l-1 of the phase: the bit that is set for
  // exactly the upper half of the period, which is what clkOut follows.
  function automatic logic [PW-1:0] halfBit(input logic [LW-1:0] l);
    halfBit = PW'(((PW + 1)'(1) << l) >> 1);
  endfunction

  always_comb begin
    reqClamped = bus.log2Ratio;
    if (bus.log2Ratio == '0) begin
      reqClamped = MIN_L;
    end else if (bus.log2Ratio > MAX_L) begin
      reqClamped = MAX_L;
    end

    phaseInc    = phase + PW'(1);
    atWrap      = (phase == lastPhase(activeLog2));
    ratioChange = (pendingLog2 != activeLog2);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values (e.g. ratioChange compares the old pending
  // and active ratios) regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      activeLog2  <= DEFAULT_L;
      pendingLog2 <= DEFAULT_L;
      strobe      <= 1'b0;
      clkOut      <= 1'b0;
      ratioAck    <= 1'b0;
    end else begin
      // The request is tracked every cycle, even while frozen, so the most
      // recent request is the one adopted at the next boundary.
      pendingLog2 <= reqClamped;

`ifdef DECIM_CLK_SYNC_EN
      if (bus.syncIn) begin
        phase      <= '0;
        clkOut     <= 1'b0;
        strobe     <= 1'b0;
        activeLog2 <= pendingLog2;
        ratioAck   <= ratioChange;
      end else
`endif
      if (!bus.enable) begin
        // Frozen: phase, clkOut and activeLog2 hold; pulses are suppressed.
        strobe   <= 1'b0;
        ratioAck <= 1'b0;
      end else if (atWrap) begin
        // Period boundary: the completed period still gets its strobe, and
        // this is the only point where a pending ratio change is adopted.
        phase      <= '0;
        clkOut     <= 1'b0;
        strobe     <= 1'b1;
        activeLog2 <= pendingLog2;
        ratioAck   <= ratioChange;
      end else begin
        phase    <= phaseInc;
        clkOut   <= |(phaseInc & halfBit(activeLog2));
        strobe   <= 1'b0;
        ratioAck <= 1'b0;
      end
    end
  end

  assign bus.phase      = phase;
  assign bus.activeLog2 = activeLog2;
  assign bus.strobe     = strobe;
  assign bus.clkOut     = clkOut;
  assign bus.ratioAck   = ratioAck;

endmodule : decim_clk_gen

// File: tb/tb_decim_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_decim_clk_gen
//
// Self-checking bench for decim_clk_gen (MAX_LOG2=8, DEFAULT_LOG2=6).
// A vector table of {inputs, cycle count, expected outputs} covers reset,
// ratio changes, clamping, freezing and mid-period reset; hand-written
// sequences cover strobe spacing and re-enable latency; a randomized run is
// compared every cycle against a period-based reference model. With
// DECIM_CLK_SYNC_EN a second generator is added to check phase alignment.
// -----------------------------------------------------------------------------
module tb_decim_clk_gen;

  localparam int MAX_LOG2     = 8;
  localparam int DEFAULT_LOG2 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  decim_clk_if #(.MAX_LOG2(MAX_LOG2)) bus ();

  decim_clk_gen #(
    .MAX_LOG2    (MAX_LOG2),
    .DEFAULT_LOG2(DEFAULT_LOG2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef DECIM_CLK_SYNC_EN
  decim_clk_if #(.MAX_LOG2(MAX_LOG2)) bus2 ();

  decim_clk_gen #(
    .MAX_LOG2    (MAX_LOG2),
    .DEFAULT_LOG2(DEFAULT_LOG2)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  // Lets the second generator be held back so it starts out of phase.
  bit en2Gate = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: tracks how many enabled cycles of the current period
  // have elapsed and the period length 2^mL; outputs are derived from those.
  int mL;
  int mPend;
  int mElapsed;
  bit mStrobe;
  bit mAck;

  typedef struct {
    bit rst;
    bit en;
    int req;
    int n;
    int ePhase;
    bit eClk;
    bit eStrobe;
    int eActive;
    bit eAck;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelStep(input bit r, input bit en, input int req, input bit sy);
    int clamped;
    clamped = (req == 0) ? 1 : ((req > MAX_LOG2) ? MAX_LOG2 : req);
    if (r) begin
      mL       = DEFAULT_LOG2;
      mPend    = DEFAULT_LOG2;
      mElapsed = 0;
      mStrobe  = 1'b0;
      mAck     = 1'b0;
    end else begin
      if (sy) begin
        mAck     = (mPend != mL);
        mL       = mPend;
        mElapsed = 0;
        mStrobe  = 1'b0;
      end else if (!en) begin
        mStrobe = 1'b0;
        mAck    = 1'b0;
      end else begin
        mElapsed++;
        if (mElapsed == (1 << mL)) begin
          mStrobe  = 1'b1;
          mAck     = (mPend != mL);
          mL       = mPend;
          mElapsed = 0;
        end else begin
          mStrobe = 1'b0;
          mAck    = 1'b0;
        end
      end
      mPend = clamped;
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, sample 1 ns later.
  task automatic tick(input bit r, input bit en, input int req, input bit sy);
    rst           = r;
    bus.enable    = en;
    bus.log2Ratio = req[3:0];
`ifdef DECIM_CLK_SYNC_EN
    bus.syncIn     = sy;
    bus2.enable    = en & en2Gate;
    bus2.log2Ratio = req[3:0];
    bus2.syncIn    = sy;
`endif
    @(posedge clk);
    modelStep(r, en, req, sy);
    #1;
  endtask

  task automatic checkModel(input string tag);
    check({tag, " phase"},  32'(bus.phase),      32'(mElapsed));
    check({tag, " clkOut"}, 32'(bus.clkOut),     32'(2 * mElapsed >= (1 << mL)));
    check({tag, " strobe"}, 32'(bus.strobe),     32'(mStrobe));
    check({tag, " ack"},    32'(bus.ratioAck),   32'(mAck));
    check({tag, " active"}, 32'(bus.activeLog2), 32'(mL));
  endtask

  initial begin
    int strobeAt[$];
    int highCount;
    int n;
    bit seen;

    //           rst en req   n   phase clk stb act ack
    vecs.push_back('{1, 0,  6,   2,   0, 0, 0, 6, 0});  // reset state
    vecs.push_back('{0, 1,  6,  31,  31, 0, 0, 6, 0});  // low half
    vecs.push_back('{0, 1,  6,   1,  32, 1, 0, 6, 0});  // clkOut rises at T/2
    vecs.push_back('{0, 1,  6,  31,  63, 1, 0, 6, 0});
    vecs.push_back('{0, 1,  6,   1,   0, 0, 1, 6, 0});  // first strobe, cycle 64
    vecs.push_back('{0, 1,  6,  10,  10, 0, 0, 6, 0});
    vecs.push_back('{0, 1,  3,   1,  11, 0, 0, 6, 0});  // request 3 at phase 10
    vecs.push_back('{0, 1,  3,  52,  63, 1, 0, 6, 0});  // old period runs out
    vecs.push_back('{0, 1,  3,   1,   0, 0, 1, 3, 1});  // strobe + ack together
    vecs.push_back('{0, 1,  3,   4,   4, 1, 0, 3, 0});
    vecs.push_back('{0, 1,  3,   4,   0, 0, 1, 3, 0});  // new period is 8 cycles
    vecs.push_back('{0, 1,  3,   5,   5, 1, 0, 3, 0});
    vecs.push_back('{0, 0,  3,  20,   5, 1, 0, 3, 0});  // frozen
    vecs.push_back('{0, 1,  3,   2,   7, 1, 0, 3, 0});
    vecs.push_back('{0, 1,  3,   1,   0, 0, 1, 3, 0});
    vecs.push_back('{0, 1,  4,   3,   3, 0, 0, 3, 0});  // pending 4 ...
    vecs.push_back('{1, 1,  4,   1,   0, 0, 0, 6, 0});  // ... discarded by reset
    vecs.push_back('{0, 1,  6,  63,  63, 1, 0, 6, 0});
    vecs.push_back('{0, 1,  6,   1,   0, 0, 1, 6, 0});  // 64 after release
    vecs.push_back('{0, 1,  0,  64,   0, 0, 1, 1, 1});  // 0 clamps to 1
    vecs.push_back('{0, 1,  0,   1,   1, 1, 0, 1, 0});
    vecs.push_back('{0, 1,  0,   1,   0, 0, 1, 1, 0});  // strobe every 2
    vecs.push_back('{0, 1, 15,   1,   1, 1, 0, 1, 0});
    vecs.push_back('{0, 1, 15,   1,   0, 0, 1, 8, 1});  // 15 clamps to 8
    vecs.push_back('{0, 1, 15, 128, 128, 1, 0, 8, 0});
    vecs.push_back('{0, 1, 15, 127, 255, 1, 0, 8, 0});
    vecs.push_back('{0, 1, 15,   1,   0, 0, 1, 8, 0});  // 256-cycle period
    vecs.push_back('{0, 1,  5,  10,  10, 0, 0, 8, 0});  // request away ...
    vecs.push_back('{0, 1,  8, 246,   0, 0, 1, 8, 0});  // ... and back: no ack

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].rst, vecs[i].en, vecs[i].req, 1'b0);
      check($sformatf("vec%0d phase", i),  32'(bus.phase),      32'(vecs[i].ePhase));
      check($sformatf("vec%0d clkOut", i), 32'(bus.clkOut),     32'(vecs[i].eClk));
      check($sformatf("vec%0d strobe", i), 32'(bus.strobe),     32'(vecs[i].eStrobe));
      check($sformatf("vec%0d active", i), 32'(bus.activeLog2), 32'(vecs[i].eActive));
      check($sformatf("vec%0d ack", i),    32'(bus.ratioAck),   32'(vecs[i].eAck));
    end

    // Strobe spacing and duty over 200 cycles at ratio 6.
    tick(1'b1, 1'b0, 6, 1'b0);
    highCount = 0;
    for (int c = 1; c <= 200; c++) begin
      tick(1'b0, 1'b1, 6, 1'b0);
      if (bus.strobe) strobeAt.push_back(c);
      if (c <= 192 && bus.clkOut) highCount++;
    end
    check("t1 strobe count", 32'(strobeAt.size()), 32'd3);
    for (int i = 0; i < strobeAt.size() && i < 3; i++)
      check($sformatf("t1 strobe%0d cycle", i), 32'(strobeAt[i]), 32'(64 * (i + 1)));
    check("t1 clkOut high cycles", 32'(highCount), 32'd96);

    // Freeze at phase 40, then measure time to the next strobe.
    n = 0;
    while (bus.phase != 8'd40 && n < 100) begin
      tick(1'b0, 1'b1, 6, 1'b0);
      n++;
    end
    check("t4 reach phase 40", 32'(bus.phase), 32'd40);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0, 6, 1'b0);
      seen |= bus.strobe;
    end
    check("t4 frozen phase", 32'(bus.phase), 32'd40);
    check("t4 frozen clkOut", 32'(bus.clkOut), 32'd1);
    check("t4 frozen strobe", 32'(seen), 32'd0);
    n = 0;
    do begin
      tick(1'b0, 1'b1, 6, 1'b0);
      n++;
    end while (!bus.strobe && n < 100);
    check("t4 cycles to strobe", 32'(n), 32'd24);

`ifdef DECIM_CLK_SYNC_EN
    // Start dut2 seven cycles late, then align both with one syncIn pulse.
    tick(1'b1, 1'b0, 6, 1'b0);
    en2Gate = 1'b0;
    for (int k = 0; k < 7; k++) tick(1'b0, 1'b1, 6, 1'b0);
    en2Gate = 1'b1;
    for (int k = 0; k < 13; k++) tick(1'b0, 1'b1, 6, 1'b0);
    check("t6 pre-sync phase", 32'(bus.phase), 32'd20);
    tick(1'b0, 1'b1, 6, 1'b1);
    check("t6 sync phase",   32'(bus.phase),   32'd0);
    check("t6 sync clkOut",  32'(bus.clkOut),  32'd0);
    check("t6 sync strobe",  32'(bus.strobe),  32'd0);
    check("t6 sync phase2",  32'(bus2.phase),  32'd0);
    check("t6 sync strobe2", 32'(bus2.strobe), 32'd0);
    n = 0;
    highCount = 0;
    do begin
      tick(1'b0, 1'b1, 6, 1'b0);
      n++;
      if (bus.strobe !== bus2.strobe || bus.phase !== bus2.phase) highCount++;
    end while (!bus.strobe && n < 100);
    check("t6 cycles to strobe", 32'(n), 32'd64);
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 1'b1, 6, 1'b0);
      if (bus.strobe !== bus2.strobe || bus.phase !== bus2.phase) highCount++;
    end
    check("t6 instances differ", 32'(highCount), 32'd0);
`endif

    // Randomized run against the reference model.
    tick(1'b1, 1'b0, 6, 1'b0);
    checkModel("rnd reset");
    begin
      int req;
      req = 2;
      for (int c = 0; c < 4000; c++) begin
        bit r, en, sy;
        r  = ($urandom_range(0, 299) == 0);
        en = ($urandom_range(0, 9) < 8);
        sy = 1'b0;
`ifdef DECIM_CLK_SYNC_EN
        sy = ($urandom_range(0, 149) == 0);
`endif
        if ($urandom_range(0, 39) == 0)
          req = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
        tick(r, en, req, sy);
        checkModel($sformatf("rnd%0d", c));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decim_clk_gen
